// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen
//   Raster timing generator and test-pattern source for the LCD panel path.
//   Free-running h/v counters drive hsync, vsync and data_en; an RGB pixel
//   stream with row/col tags is produced alongside. All outputs are
//   registered and leave one clock after the counters hold the position
//   they describe.
//
//   Line order is active, front porch, sync, back porch (same vertically).
//
// Ports
//   clock        pixel clock
//   reset        asynchronous active-high reset; release must be synchronous
//                to clock (driven by the upstream reset synchroniser)
//   en           run enable; low parks the counters at (0,0) and idles outputs
//   mode         0 colour bars, 1 checkerboard, 2 grey ramp, 3 solid colour
//                (latched at the start of each frame)
//   solid_rgb    {R,G,B} used by mode 3, sampled live
//   hsync/vsync  active-low syncs
//   data_en      high for active pixels
//   R, G, B      pixel colour, zero outside the active area
//   row, col     active line / pixel index, zero outside the active area
//   frame_start  one-cycle pulse together with pixel (0,0)
//   frame_cnt    completed frames, wraps 65535 -> 0
//
// Optional build macro
//   PATTERN_SCROLL_EN  when defined, the bar colour index is offset by
//                      frame_cnt[2:0] so the bars shift one entry per frame.

module lcd_pattern_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 160,
  parameter int H_SYNC     = 20,
  parameter int H_BP       = 140,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 12,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 20,
  parameter int NUM_BARS   = 5,
  parameter int CHECK_LOG2 = 5,
  parameter int COLOR_W    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic [3*COLOR_W-1:0]          solid_rgb,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          data_en,
  output logic [COLOR_W-1:0]            R,
  output logic [COLOR_W-1:0]            G,
  output logic [COLOR_W-1:0]            B,
  output logic [$clog2(V_ACTIVE)-1:0]   row,
  output logic [$clog2(H_ACTIVE)-1:0]   col,
  output logic                          frame_start,
  output logic [15:0]                   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit so every boundary (including the totals) is representable.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int ROW_W   = $clog2(V_ACTIVE);
  localparam int COL_W   = $clog2(H_ACTIVE);
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int BI_W    = $clog2(NUM_BARS + 1);

  localparam logic [HW-1:0]   H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]   V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0]   BAR_LAST   = HW'(BAR_W - 1);
  localparam logic [BI_W-1:0] BI_LAST    = BI_W'(NUM_BARS - 1);

  // Bar colour table as {r_on, g_on, b_on}.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b001; // blue
      3'd1:    rgb = 3'b101; // magenta
      3'd2:    rgb = 3'b110; // yellow
      3'd3:    rgb = 3'b100; // red
      3'd4:    rgb = 3'b111; // white
      3'd5:    rgb = 3'b010; // green
      3'd6:    rgb = 3'b011; // cyan
      default: rgb = 3'b000; // black
    endcase
    return rgb;
  endfunction

  // Counter state
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [HW-1:0]   bar_pix_q, bar_pix_d;
  logic [BI_W-1:0] bar_idx_q, bar_idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  // Output registers
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               data_en_q, data_en_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               frame_start_q, frame_start_d;

  // Decoded position
  logic       at_origin_s;
  logic       at_last_s;
  logic       active_s;
  logic [1:0] mode_eff_s;
  logic [2:0] bar_sel_s;
  logic [2:0] bar_on_s;
  logic       chk_black_s;

  assign at_origin_s = (h_cnt_q == {HW{1'b0}}) && (v_cnt_q == {VW{1'b0}});
  assign at_last_s   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign active_s    = en && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  // A new mode applies from pixel (0,0) onward; mid-frame changes wait.
  assign mode_eff_s  = at_origin_s ? mode : mode_q;

`ifdef PATTERN_SCROLL_EN
  assign bar_sel_s = 3'(bar_idx_q) + frame_cnt_q[2:0];
`else
  assign bar_sel_s = 3'(bar_idx_q);
`endif

  assign bar_on_s    = bar_colour(bar_sel_s);
  assign chk_black_s = |(((32'(h_cnt_q) ^ 32'(v_cnt_q)) >> CHECK_LOG2) & 32'd1);

  // Raster counters, in-bar tracking, mode latch and frame counter next state
  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    bar_pix_d   = bar_pix_q;
    bar_idx_d   = bar_idx_q;
    mode_d      = mode_eff_s;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      h_cnt_d   = {HW{1'b0}};
      v_cnt_d   = {VW{1'b0}};
      bar_pix_d = {HW{1'b0}};
      bar_idx_d = {BI_W{1'b0}};
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d   = {HW{1'b0}};
      bar_pix_d = {HW{1'b0}};
      bar_idx_d = {BI_W{1'b0}};
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = {VW{1'b0}};
      end else begin
        v_cnt_d = v_cnt_q + {{(VW-1){1'b0}}, 1'b1};
      end
    end else begin
      h_cnt_d = h_cnt_q + {{(HW-1){1'b0}}, 1'b1};
      // The last bar never advances, so it absorbs the width remainder.
      if ((bar_pix_q == BAR_LAST) && (bar_idx_q != BI_LAST)) begin
        bar_pix_d = {HW{1'b0}};
        bar_idx_d = bar_idx_q + {{(BI_W-1){1'b0}}, 1'b1};
      end else begin
        bar_pix_d = bar_pix_q + {{(HW-1){1'b0}}, 1'b1};
      end
    end
    if (en && at_last_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Sync, enable, tag and pixel colour for the current counter position
  always_comb begin
    hsync_d       = ~(en && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    vsync_d       = ~(en && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
    data_en_d     = active_s;
    frame_start_d = en && at_origin_s;
    r_d           = {COLOR_W{1'b0}};
    g_d           = {COLOR_W{1'b0}};
    b_d           = {COLOR_W{1'b0}};
    row_d         = {ROW_W{1'b0}};
    col_d         = {COL_W{1'b0}};
    if (active_s) begin
      row_d = ROW_W'(v_cnt_q);
      col_d = COL_W'(h_cnt_q);
      case (mode_eff_s)
        2'd0: begin
          r_d = {COLOR_W{bar_on_s[2]}};
          g_d = {COLOR_W{bar_on_s[1]}};
          b_d = {COLOR_W{bar_on_s[0]}};
        end
        2'd1: begin
          r_d = {COLOR_W{~chk_black_s}};
          g_d = {COLOR_W{~chk_black_s}};
          b_d = {COLOR_W{~chk_black_s}};
        end
        2'd2: begin
          r_d = COLOR_W'(h_cnt_q);
          g_d = COLOR_W'(h_cnt_q);
          b_d = COLOR_W'(h_cnt_q);
        end
        2'd3: begin
          r_d = solid_rgb[3*COLOR_W-1:2*COLOR_W];
          g_d = solid_rgb[2*COLOR_W-1:COLOR_W];
          b_d = solid_rgb[COLOR_W-1:0];
        end
        default: begin
          r_d = {COLOR_W{1'b0}};
          g_d = {COLOR_W{1'b0}};
          b_d = {COLOR_W{1'b0}};
        end
      endcase
    end else begin
      row_d = {ROW_W{1'b0}};
      col_d = {COL_W{1'b0}};
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= {HW{1'b0}};
      v_cnt_q       <= {VW{1'b0}};
      bar_pix_q     <= {HW{1'b0}};
      bar_idx_q     <= {BI_W{1'b0}};
      mode_q        <= 2'd0;
      frame_cnt_q   <= 16'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      data_en_q     <= 1'b0;
      r_q           <= {COLOR_W{1'b0}};
      g_q           <= {COLOR_W{1'b0}};
      b_q           <= {COLOR_W{1'b0}};
      row_q         <= {ROW_W{1'b0}};
      col_q         <= {COL_W{1'b0}};
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_pix_q     <= bar_pix_d;
      bar_idx_q     <= bar_idx_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      data_en_q     <= data_en_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign data_en     = data_en_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign row         = row_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
